// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the sequence detector: state encodings ({y2,y1}),
// LED bit positions and default timing constants.
package seq_detect_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WAIT00 = 2'b01,
        S_GOT10  = 2'b10,
        S_DET    = 2'b11
    } state_t;

    localparam int LED_Y2      = 0;
    localparam int LED_Y1      = 1;
    localparam int LED_MODE    = 2;
    localparam int LED_Z       = 7;
    localparam int LED_CNT_LSB = 8;

    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int AUTO_PERIOD_DEF     = 100000000;

endpackage

// File: rtl/seq_debounce.sv
// Two-flop synchronizer plus optional stability filter (enabled by SEQ_DEBOUNCE_EN).
// Without the macro the filtered output is the synchronized value, forced low in reset.
module seq_debounce
    import seq_detect_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync_out,
    output logic filt_out
);

    logic meta_r;
    logic sync_r;

    if ((DEBOUNCE_CYCLES < 1) || (CNT_W < $clog2(DEBOUNCE_CYCLES + 1))) begin : g_cfg_check
        $error("seq_debounce: DEBOUNCE_CYCLES must be >= 1 and fit in CNT_W bits");
    end

    // Synchronizer flops are left unreset so the input stays visible during reset
    always_ff @(posedge clk) begin
        meta_r <= din;
        sync_r <= meta_r;
    end

    assign sync_out = sync_r;

`ifdef SEQ_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt_r;
    logic             filt_r;

    // Filtered level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            filt_r <= 1'b0;
        end else if (sync_r == filt_r) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_r  <= '0;
            filt_r <= sync_r;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign filt_out = filt_r;
`else
    assign filt_out = sync_r & rst_n;
`endif

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequence detector controller: step/auto advance, {y2,y1} FSM, Moore z and detect count.
// Define SEQ_DEBOUNCE_EN to debounce btn_step and the mode switch.
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int AUTO_PERIOD     = AUTO_PERIOD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  sw_pin,
    input  logic        btn_step,
    output logic [15:0] led_pin
);

    localparam int TICK_W = $clog2(AUTO_PERIOD + 1);

    logic [1:0]        x_meta_r;
    logic [1:0]        x_sync_r;
    logic              btn_sync_s;
    logic              btn_filt_s;
    logic              mode_sync_s;
    logic              mode_filt_s;
    logic              btn_prev_r;
    logic              btn_armed_r;
    logic [TICK_W-1:0] tick_cnt_r;
    logic              step_s;
    logic              tick_s;
    logic              advance_s;
    state_t            state_r;
    state_t            nxt_s;
    logic [1:0]        y_s;
    logic              z_r;
    logic [7:0]        det_cnt_r;
    logic              unused_sw_s;

    // Switches [5:1] are spare inputs with no function
    assign unused_sw_s = ^sw_pin[5:1];

    function automatic state_t next_state(input state_t cur, input logic [1:0] x);
        state_t nxt;
        case (cur)
            S_IDLE: begin
                case (x)
                    2'b00:   nxt = S_IDLE;
                    2'b10:   nxt = S_GOT10;
                    default: nxt = S_WAIT00;
                endcase
            end
            S_GOT10: begin
                case (x)
                    2'b11:   nxt = S_DET;
                    2'b10:   nxt = S_GOT10;
                    2'b00:   nxt = S_IDLE;
                    default: nxt = S_WAIT00;
                endcase
            end
            S_WAIT00: begin
                case (x)
                    2'b00:   nxt = S_IDLE;
                    default: nxt = S_WAIT00;
                endcase
            end
            S_DET: begin
                case (x)
                    2'b11:   nxt = S_DET;
                    2'b00:   nxt = S_IDLE;
                    default: nxt = S_WAIT00;
                endcase
            end
            default: nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

    // Two-flop synchronizer for the sequence input pair {x2,x1}
    always_ff @(posedge clk) begin
        x_meta_r <= sw_pin[7:6];
        x_sync_r <= x_meta_r;
    end

    seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_deb (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (btn_step),
        .sync_out (btn_sync_s),
        .filt_out (btn_filt_s)
    );

    seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_deb (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (sw_pin[0]),
        .sync_out (mode_sync_s),
        .filt_out (mode_filt_s)
    );

    // Edge history; arming requires a released button so a press held through reset is ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_prev_r  <= 1'b0;
            btn_armed_r <= 1'b0;
        end else begin
            btn_prev_r <= btn_filt_s;
            if (!btn_sync_s) begin
                btn_armed_r <= 1'b1;
            end
        end
    end

    assign step_s    = btn_filt_s & ~btn_prev_r & btn_armed_r;
    assign tick_s    = mode_filt_s & (tick_cnt_r == TICK_W'(AUTO_PERIOD - 1));
    assign advance_s = mode_filt_s ? tick_s : step_s;

    // Auto-mode period counter, held at zero whenever step mode is selected
    always_ff @(posedge clk) begin
        if (!rst_n || !mode_filt_s) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    assign nxt_s = next_state(state_r, x_sync_r);

    // Detector FSM with registered z and detect count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            z_r       <= 1'b0;
            det_cnt_r <= 8'd0;
        end else if (advance_s) begin
            state_r <= nxt_s;
            z_r     <= (nxt_s == S_DET);
            if ((state_r == S_GOT10) && (nxt_s == S_DET)) begin
                det_cnt_r <= det_cnt_r + 8'd1;
            end
        end
    end

    assign y_s = state_r;

    // LED map driven straight from registers
    always_comb begin
        led_pin                       = 16'h0000;
        led_pin[LED_Y2]               = y_s[1];
        led_pin[LED_Y1]               = y_s[0];
        led_pin[LED_MODE]             = mode_sync_s;
        led_pin[LED_Z]                = z_r;
        led_pin[LED_CNT_LSB +: 8]     = det_cnt_r;
    end

endmodule
